// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared opcode/field-width definitions and fetch FSM states
package fetch_stage_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 8;
   localparam int OPC_W       = 3;

   // Opcodes understood by decode; encodings 5..7 are unassigned
   typedef enum logic [OPC_W-1:0] {
      ADD  = 3'd0,
      NAND = 3'd1,
      SHFT = 3'd2,
      INIT = 3'd3,
      STOR = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
      logic legal;
      case (op)
         ADD, NAND, SHFT, INIT, STOR: legal = 1'b1;
         default:                     legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, one-outstanding imem fetch, IR handoff to decode (optional FETCH_ILLEGAL_TRAP_EN)
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int INSTR_W  = DEF_INSTR_W,
   parameter int OPCODE_W = OPC_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        run,
   input  logic                        pc_load,
   input  logic [ADDR_W-1:0]           pc_load_val,
   output logic                        imem_req,
   output logic [ADDR_W-1:0]           imem_addr,
   input  logic                        imem_ack,
   input  logic [INSTR_W-1:0]          imem_rdata,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output opcode_e                     opcode,
   output logic [INSTR_W-OPCODE_W-1:0] operand,
   output logic [ADDR_W-1:0]           instr_pc,
   output logic                        busy
`ifdef FETCH_ILLEGAL_TRAP_EN
   ,
   output logic                        illegal
`endif
);

   fetch_state_e        state_q;
   fetch_state_e        state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   shadow_q;
   logic [ADDR_W-1:0]   instr_pc_q;
   logic [INSTR_W-1:0]  ir_q;
   logic                flush_pend_q;

   logic accept;
   logic discard;
   logic capture;
   logic transfer;
   logic trap;

   // A response arrives; it is thrown away if a redirect is pending or arrives with it
   assign accept   = (state_q == REQ) && imem_ack;
   assign discard  = accept && (flush_pend_q || pc_load);
   assign capture  = accept && !discard;
   assign transfer = (state_q == HOLD) && instr_ready;

`ifdef FETCH_ILLEGAL_TRAP_EN
   logic illegal_q;

   // Trap flag follows each captured word; only a PC load releases it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else if (pc_load && (state_q != REQ)) begin
         illegal_q <= 1'b0;
      end else if (capture) begin
         illegal_q <= !is_legal_opcode(imem_rdata[INSTR_W-1 -: OPCODE_W]);
      end
   end

   assign trap    = illegal_q;
   assign illegal = illegal_q;
`else
   assign trap = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a redirect from IDLE/HOLD restarts per run; a flushed ack idles one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pc_load) begin
               state_d = run ? REQ : IDLE;
            end else if (run && !trap) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (accept) begin
               state_d = discard ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (pc_load) begin
               state_d = run ? REQ : IDLE;
            end else if (transfer) begin
               state_d = (run && !trap) ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state
   always_comb begin
      imem_req    = (state_q == REQ);
      instr_valid = (state_q == HOLD);
      busy        = (state_q != IDLE);
   end

   // PC, IR and redirect shadow; a load during REQ waits for the ack so the address stays stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= '0;
         ir_q         <= '0;
         instr_pc_q   <= '0;
         shadow_q     <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         if (capture) begin
            ir_q       <= imem_rdata;
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + ADDR_W'(1);
         end else if (discard) begin
            pc_q <= pc_load ? pc_load_val : shadow_q;
         end else if (pc_load && (state_q != REQ)) begin
            pc_q <= pc_load_val;
         end

         if (accept) begin
            flush_pend_q <= 1'b0;
         end else if ((state_q == REQ) && pc_load) begin
            flush_pend_q <= 1'b1;
            shadow_q     <= pc_load_val;
         end
      end
   end

   assign imem_addr = pc_q;
   assign instr_pc  = instr_pc_q;
   assign opcode    = opcode_e'(ir_q[INSTR_W-1 -: OPCODE_W]);
   assign operand   = ir_q[INSTR_W-OPCODE_W-1:0];

endmodule
